// File: rtl/ssd_scan_capture.sv
// ssd_scan_capture: snoops a multiplexed 4-digit seven-segment bus and rebuilds the displayed codes
module ssd_scan_capture #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ssd_in,
    input  logic [7:0] seg_in,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig_valid,
    output logic [3:0] dig_err,
    output logic       frame_done,
    output logic       sel_err
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [TIMEOUT_W-1:0] TMAX = '1;

    logic [11:0]          samp;
    logic [CW-1:0]        cnt;
    logic [TIMEOUT_W-1:0] tmo [4];
    logic [3:0]           digs [4];
    logic [3:0]           seen, cap_mask, nxt_seen;
    logic                 eq, cap, one_cold;
    logic [4:0]           dec;

    // {err, code}; "S" shares the "5" glyph so it lands on 5, and 11 is never produced
    function automatic logic [4:0] decode(input logic [7:0] p);
        case (p)
            8'h03: decode = 5'd0;
            8'h9F: decode = 5'd1;
            8'h25: decode = 5'd2;
            8'h0D: decode = 5'd3;
            8'h99: decode = 5'd4;
            8'h49: decode = 5'd5;
            8'h41: decode = 5'd6;
            8'h1F: decode = 5'd7;
            8'h01: decode = 5'd8;
            8'h09: decode = 5'd9;
            8'h11: decode = 5'd10;
            8'h2B: decode = 5'd12;
            8'hFD: decode = 5'd14;
            8'hFE: decode = 5'd15;
            default: decode = 5'h1F;
        endcase
    endfunction

    assign dig0 = digs[0];
    assign dig1 = digs[1];
    assign dig2 = digs[2];
    assign dig3 = digs[3];

    // capture fires once per dwell, using the registered sample (equal to the input on that edge)
    always_comb begin
        eq       = {ssd_in, seg_in} == samp;
        cap      = eq && cnt == CW'(STABLE_CYC - 1);
        one_cold = $onehot(~samp[11:8]);
        cap_mask = (cap && one_cold) ? ~samp[11:8] : 4'b0000;
        nxt_seen = seen | cap_mask;
        dec      = decode(samp[7:0]);
    end

    // sample/stability tracking, per-digit capture, refresh timeouts and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            samp       <= 12'hFFF;
            cnt        <= '0;
            seen       <= '0;
            dig_valid  <= '0;
            dig_err    <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                digs[k] <= '0;
                tmo[k]  <= '0;
            end
        end else begin
            samp       <= {ssd_in, seg_in};
            cnt        <= !eq ? '0 : (cnt == CW'(STABLE_CYC) ? cnt : cnt + 1'b1);
            sel_err    <= cap && !one_cold && samp[11:8] != 4'hF;
            frame_done <= nxt_seen == 4'hF;
            seen       <= nxt_seen == 4'hF ? 4'h0 : nxt_seen;
            for (int k = 0; k < 4; k++) begin
                if (cap_mask[k]) begin
                    digs[k]      <= dec[3:0];
                    dig_err[k]   <= dec[4];
                    dig_valid[k] <= 1'b1;
                    tmo[k]       <= '0;
                end else begin
                    if (tmo[k] != TMAX) tmo[k] <= tmo[k] + 1'b1;
                    if (tmo[k] == TMAX - 1'b1) dig_valid[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/ssd_scan_capture.md
Name: ssd_scan_capture

Overview:
- Receiving end of the multiplexed 4-digit seven-segment bus: snoops the active-low digit-select and segment lines and reconstructs the four displayed 4-bit codes.
- Used as a loopback monitor and self-check: a display driver's select/segment outputs feed this block, and its decoded digits are compared against the driver's source counters.
- Filters mux glitches, flags undecodable patterns, and marks digits stale when their refresh stops.

Parameters:
- STABLE_CYC, 4, consecutive identical samples required before capture (min 2).
- TIMEOUT_W, 20, width of the per-digit refresh timeout counter; a digit goes stale after 2^TIMEOUT_W-1 cycles without capture.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ssd_in  input  4  digit select, active-low one-cold; bit0 = digit0 … bit3 = digit3
- seg_in  input  8  segments, active-low, {a,b,c,d,e,f,g,dp}, bit7 = a
- dig0, dig1, dig2, dig3  output  4 each  last decoded code per digit
- dig_valid  output  4  per-digit: captured and not timed out
- dig_err  output  4  per-digit: last capture was an undecodable pattern
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse
- sel_err  output  1  one-cycle pulse on a stable select that is neither one-cold nor 4'b1111

Behaviour:
- Single clock domain, clk rising edge; all state registered; reset is synchronous, active-high, and has priority over all other updates.
- Reset values:
  - dig0–dig3 = 0, dig_valid = 0, dig_err = 0, frame_done = 0, sel_err = 0.
  - Sample register = {4'b1111, 8'hFF}, stability count = 0, timeouts = 0, seen mask = 0.
- Sampling: each edge, {ssd_in, seg_in} is loaded into the sample register.
  - eq = (current input == sample register).
  - If !eq, count <= 0; else count increments, saturating at STABLE_CYC.
- Capture event: occurs when eq is true and count == STABLE_CYC-1.
  - Fires exactly once per stable dwell.
  - Latency: input first registered at edge 1; outputs update at edge STABLE_CYC+1.
- On a capture event with a one-cold select for digit k:
  - digk <= decode(seg); dig_valid[k] <= 1; dig_err[k] <= (pattern unknown).
  - timeout[k] <= 0; seen[k] <= 1.
- Decode table (seg → code):
  - 0x03→0, 0x9F→1, 0x25→2, 0x0D→3, 0x99→4, 0x49→5, 0x41→6, 0x1F→7, 0x01→8, 0x09→9.
  - 0x11→10, 0x2B→12, 0xFD→14, 0xFE→15 (blank/dp-only).
  - The "S" glyph is identical to "5" and always decodes to 5; code 11 is never produced.
  - Any other pattern → code 15 with dig_err[k] = 1.
- Select 4'b1111 (all off) never captures and raises no error.
- Any other non-one-cold select reaching a capture event:
  - No digit is updated.
  - sel_err pulses for one cycle on that edge.
- Timeout: each cycle, every digit not captured that cycle increments its timeout counter, saturating at all-ones.
  - On reaching all-ones, dig_valid[k] <= 0.
  - digk and dig_err[k] hold their values.
- frame_done: on the edge where (seen | capture mask) == 4'b1111:
  - frame_done <= 1 for one cycle.
  - seen <= 0 on the same edge; the capture that completed the frame is not carried into the next frame.
- Repeated captures of the same digit within a frame: re-update digk; frame_done does not fire until all four digits are captured.
- Reset mid-dwell: count is cleared; a dwell started before reset needs a full STABLE_CYC after reset to capture.

Test Plan:
- Reset with ssd_in = 4'b1110, seg_in = 8'h0D, held → outputs all 0 during reset; with STABLE_CYC = 4, dig0 = 3 and dig_valid = 4'b0001 at the 5th edge after reset release.
- Cycle 0111/1011/1101/1110 with 0x11/0xFD/0x99/0x03, each held 8 cycles → dig3 = 10, dig2 = 14, dig1 = 4, dig0 = 0; frame_done single pulse after the fourth capture; dig_err = 0.
- Glitch: hold 1110/0x25 for 2 cycles, then 1110/0x1F for 6 cycles → dig0 = 7 only; no capture of 2.
- Select 4'b1100 stable for 6 cycles → sel_err pulses once; no digit changes. Select 4'b1111 stable → no sel_err.
- Digit1 pattern 0x49 → dig1 = 5. Pattern 0x7E → dig1 = 15, dig_err[1] = 1.
- TIMEOUT_W = 4: capture digit2, then hold 1111 → dig_valid[2] falls 15 cycles after the capture, dig2 unchanged.
